pmem_responder: RTL and testbench
=================================

# pmem_responder

Physical-memory responder for the L1 cache's line-granular pmem port. It sits on the far side of the cache controller's `pmem_read`/`pmem_write`/`pmem_resp` handshake and owns a line-wide backing store. It accepts one request at a time, waits a programmable latency, then commits the write or returns the read line together with a single-cycle `pmem_resp`. It serves as the synthesizable main memory for the cache path and as the timing model for cache verification.

## Interface
- `LATENCY`, 4: cycles from request acceptance to `pmem_resp`; legal range 1..15.
- `INDEX_BITS`, 8: line-index width; store depth is 2^INDEX_BITS lines.
- `clk` in 1: the only clock; all logic is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `pmem_read` in 1: line read request, held by the initiator until `pmem_resp`.
- `pmem_write` in 1: line write request, held by the initiator until `pmem_resp`.
- `pmem_address` in 32: byte address; bits [4:0] are ignored and bits [4+INDEX_BITS:5] form the index.
- `pmem_wdata` in 256: write line, sampled only at acceptance.
- `pmem_rdata` out 256: read line, registered and valid in the `pmem_resp` cycle of a read.
- `pmem_resp` out 1: one-cycle completion pulse.
- `proto_err` out 1: sticky protocol-violation flag, cleared only by reset.

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE: if `pmem_read | pmem_write`, latch the op, index and `pmem_wdata`.
  - If LATENCY == 1, go to RESP.
  - Otherwise load the counter with LATENCY-2 and go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 0, go to RESP.
- RESP: assert `pmem_resp` and return to IDLE.
  - Write: commit the latched wdata to the latched index in this cycle.
  - Read: `pmem_rdata` presents the store contents at the latched index.
- Requests are never queued. IDLE in the cycle after RESP samples a new request, so a write-back can be followed immediately by a fill.
- `pmem_read` and `pmem_write` both high at acceptance: treat as a write and set `proto_err`.
- Request deasserted while in WAIT: the transaction still completes (resp pulses, and the write commits if the op is a write); set `proto_err`.
- Address or wdata changing after acceptance: ignored, because the latched values are used.
- Index aliasing: address bits above 4+INDEX_BITS are ignored, so addresses wrap modulo depth.
- Read-after-write to the same index returns the new data.
- `pmem_rdata` holds its last read value in all cycles other than a read's RESP cycle.

## Timing
- A request first seen high in IDLE at cycle T produces `pmem_resp` high in cycle T+LATENCY only, and low in every other cycle.
- Minimum spacing between consecutive `pmem_resp` pulses is LATENCY+1 cycles.
- Reset values:
  - state = IDLE
  - counter = 0
  - `pmem_resp` = 0
  - `pmem_rdata` = 0
  - `proto_err` = 0
  - The store array is not reset.
- Reset mid-transaction: return to IDLE with no commit and no resp pulse. A request still held when `rst_n` releases is accepted in the first IDLE cycle.

## Structure
- Package `pmem_types`:
  - `PMEM_LINE_W` = 256
  - `PMEM_OFFSET_BITS` = 5
  - typedef `pmem_line_t` (logic [255:0])
  - enum `pmem_state_t` {IDLE, WAIT, RESP}
- Sub-module `line_array`: 2^INDEX_BITS × 256 storage, one synchronous write port and one synchronous read port, no reset.
  - The top level issues the array read one cycle before RESP (or at acceptance when LATENCY == 1), so `pmem_rdata` is registered in RESP.
- Top level contains the FSM, the latency counter, the request latches and the error logic.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `pmem_read`=1 → `pmem_resp`, `pmem_rdata` and `proto_err` all 0. After release, `pmem_resp` pulses exactly LATENCY cycles after the first IDLE cycle.
- Write then read, LATENCY=4: write 0xA5…A5 to address 0x0000_0040, then read 0x0000_0040 → each `pmem_resp` comes 4 cycles after its request, and the read returns 0xA5…A5.
- Back-to-back: write-back to 0x100 followed in the very next cycle by a read of 0x200 → two resp pulses 5 cycles apart; the read returns the prior contents of 0x200, unaffected by the write to 0x100.
- Aliasing and offset: with INDEX_BITS=8, write to 0x0000_2020, then read 0x0000_0020 and 0x0000_003F → both reads return the written line.
- Protocol errors:
  - Assert both strobes at acceptance → handled as a write and `proto_err`=1.
  - Drop `pmem_read` during WAIT → resp still pulses and `proto_err` stays 1 until reset.
- LATENCY=1 and reset mid-WAIT:
  - LATENCY=1 → resp arrives in the cycle after acceptance.
  - Assert reset during WAIT of a write → no resp pulse, and a later read returns the old data.

Source files
------------

// File: rtl/pmem_responder_pkg.sv
// Shared types for the pmem responder.
// Line width, address offset width, latency counter width, the FSM state
// encoding and the latched operation kind.
package pmem_types;

    localparam int unsigned PMEM_LINE_W      = 256;
    localparam int unsigned PMEM_OFFSET_BITS = 5;
    localparam int unsigned PMEM_ADDR_W      = 32;
    localparam int unsigned PMEM_CNT_W       = 4;

    typedef logic [PMEM_LINE_W-1:0] pmem_line_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } pmem_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } pmem_op_t;

endpackage

// File: rtl/pmem_responder_if.sv
// Line-granular pmem handshake between the cache controller and memory.
//   pmem_read/pmem_write : request strobes, held until pmem_resp
//   pmem_address         : byte address
//   pmem_wdata           : write line
//   pmem_rdata           : read line, valid with pmem_resp of a read
//   pmem_resp            : one-cycle completion pulse
interface pmem_responder_if;
    import pmem_types::*;

    logic                   pmem_read;
    logic                   pmem_write;
    logic [PMEM_ADDR_W-1:0] pmem_address;
    pmem_line_t             pmem_wdata;
    pmem_line_t             pmem_rdata;
    logic                   pmem_resp;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/pmem_responder_line_array.sv
// Line-wide backing store: one synchronous write port, one synchronous
// read port with a registered output, no reset on storage.
//   clk                : clock
//   i_wr_en/i_wr_idx/i_wr_data : write port
//   i_rd_en/i_rd_idx   : read port, data appears after the next edge
//   o_rd_data          : last read line, held while i_rd_en is low
module line_array
    import pmem_types::*;
#(
    parameter int unsigned INDEX_BITS = 8
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_idx,
    input  pmem_line_t            i_wr_data,
    input  logic                  i_rd_en,
    input  logic [INDEX_BITS-1:0] i_rd_idx,
    output pmem_line_t            o_rd_data
);

    localparam int unsigned DEPTH = 1 << INDEX_BITS;

    pmem_line_t r_mem [DEPTH];
    pmem_line_t r_rd_data;

    // Storage and read register
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_idx];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pmem_responder.sv
// Physical-memory responder: accepts one line request at a time, waits
// LATENCY cycles, then commits a write or returns a read line with a
// single-cycle pmem_resp.
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   bus       : pmem handshake (slave side)
//   proto_err : sticky protocol-violation flag, cleared only by reset
module pmem_responder
    import pmem_types::*;
#(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned INDEX_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pmem_responder_if.slave         bus,
    output logic                    proto_err
);

    localparam logic [PMEM_CNT_W-1:0] CNT_LOAD =
        PMEM_CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

    pmem_state_t           r_state, w_state_nxt;
    logic [PMEM_CNT_W-1:0] r_cnt, w_cnt_nxt;
    pmem_op_t              r_op, w_op_nxt;
    logic [INDEX_BITS-1:0] r_idx, w_idx_nxt;
    pmem_line_t            r_wdata, w_wdata_nxt;
    logic                  r_resp, w_resp_nxt;
    logic                  r_err, w_err_nxt;
    logic                  r_rd_valid, w_rd_valid_nxt;

    logic                  w_req;
    logic                  w_op_strobe;
    logic [INDEX_BITS-1:0] w_addr_idx;
    logic [INDEX_BITS-1:0] w_rd_idx;
    logic                  w_rd_en;
    logic                  w_wr_en;
    logic                  w_arr_rd_en;
    logic                  w_arr_wr_en;
    pmem_line_t            w_arr_q;
    logic                  w_unused_addr;

    assign w_req         = bus.pmem_read | bus.pmem_write;
    assign w_addr_idx    = bus.pmem_address[PMEM_OFFSET_BITS +: INDEX_BITS];
    assign w_op_strobe   = (r_op == OP_WRITE) ? bus.pmem_write : bus.pmem_read;
    // Offset bits and aliasing high bits deliberately do not reach the index
    assign w_unused_addr = &{1'b0, bus.pmem_address};

    // Next-state, latches, counter and error logic
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_op_nxt       = r_op;
        w_idx_nxt      = r_idx;
        w_wdata_nxt    = r_wdata;
        w_resp_nxt     = 1'b0;
        w_err_nxt      = r_err;
        w_rd_valid_nxt = r_rd_valid;
        w_rd_en        = 1'b0;
        w_rd_idx       = r_idx;
        w_wr_en        = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_req) begin
                    // Both strobes high resolves to a write
                    w_op_nxt    = bus.pmem_write ? OP_WRITE : OP_READ;
                    w_idx_nxt   = w_addr_idx;
                    w_wdata_nxt = bus.pmem_wdata;
                    if (bus.pmem_read && bus.pmem_write) begin
                        w_err_nxt = 1'b1;
                    end
                    if (LATENCY == 1) begin
                        // No WAIT: array read is issued straight from the bus index
                        w_state_nxt = RESP;
                        w_resp_nxt  = 1'b1;
                        if (!bus.pmem_write) begin
                            w_rd_en        = 1'b1;
                            w_rd_idx       = w_addr_idx;
                            w_rd_valid_nxt = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt   = CNT_LOAD;
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!w_op_strobe) begin
                    w_err_nxt = 1'b1;
                end
                if (r_cnt == '0) begin
                    // Read issued one cycle early so the line is ready in RESP
                    w_state_nxt = RESP;
                    w_resp_nxt  = 1'b1;
                    if (r_op == OP_READ) begin
                        w_rd_en        = 1'b1;
                        w_rd_valid_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
                w_wr_en     = (r_op == OP_WRITE);
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and control registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_op       <= OP_READ;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_resp     <= 1'b0;
            r_err      <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_op       <= w_op_nxt;
            r_idx      <= w_idx_nxt;
            r_wdata    <= w_wdata_nxt;
            r_resp     <= w_resp_nxt;
            r_err      <= w_err_nxt;
            r_rd_valid <= w_rd_valid_nxt;
        end
    end

    // Reset suppresses any in-flight commit or read
    assign w_arr_rd_en = w_rd_en & rst_n;
    assign w_arr_wr_en = w_wr_en & rst_n;

    line_array #(
        .INDEX_BITS (INDEX_BITS)
    ) u_line_array (
        .clk       (clk),
        .i_wr_en   (w_arr_wr_en),
        .i_wr_idx  (r_idx),
        .i_wr_data (r_wdata),
        .i_rd_en   (w_arr_rd_en),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_arr_q)
    );

    // Array read register holds between reads; zero until the first read after reset
    assign bus.pmem_rdata = r_rd_valid ? w_arr_q : '0;
    assign bus.pmem_resp  = r_resp;
    assign proto_err      = r_err;

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder at LATENCY=4 and LATENCY=1.
module tb_pmem_responder;
    import pmem_types::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       b_read, b_write, sel1;
    logic [31:0] b_addr;
    pmem_line_t b_wdata;
    logic       err4, err1;
    logic       o_resp, o_err;
    pmem_line_t o_rdata;
    pmem_line_t rd;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pmem_responder_if if4 ();
    pmem_responder_if if1 ();

    assign if4.pmem_read    = b_read  & ~sel1;
    assign if4.pmem_write   = b_write & ~sel1;
    assign if4.pmem_address = b_addr;
    assign if4.pmem_wdata   = b_wdata;
    assign if1.pmem_read    = b_read  & sel1;
    assign if1.pmem_write   = b_write & sel1;
    assign if1.pmem_address = b_addr;
    assign if1.pmem_wdata   = b_wdata;

    assign o_resp  = sel1 ? if1.pmem_resp  : if4.pmem_resp;
    assign o_rdata = sel1 ? if1.pmem_rdata : if4.pmem_rdata;
    assign o_err   = sel1 ? err1 : err4;

    pmem_responder #(.LATENCY(4), .INDEX_BITS(8)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (if4.slave),
        .proto_err (err4)
    );

    pmem_responder #(.LATENCY(1), .INDEX_BITS(8)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (if1.slave),
        .proto_err (err1)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One idle cycle after a response; the pulse must already be gone
    task automatic gap();
        step(1);
        check("gap_resp", 256'(o_resp), 256'(0));
    endtask

    // Issue a request and measure cycles to pmem_resp; address/wdata are
    // scrambled after acceptance, and strobes dropped at drop_at if nonzero
    task automatic xfer(input string tag, input logic r, input logic w,
                        input logic [31:0] addr, input pmem_line_t wd,
                        input int exp_lat, input int drop_at,
                        output pmem_line_t rdata);
        int k;
        bit seen;
        k    = 0;
        seen = 1'b0;
        b_read  = r;
        b_write = w;
        b_addr  = addr;
        b_wdata = wd;
        while (!seen && k < 20) begin
            step(1);
            k++;
            if (k == 2) begin
                b_addr  = addr ^ 32'h0000_0FE0;
                b_wdata = ~wd;
            end
            if (k == drop_at) begin
                b_read  = 1'b0;
                b_write = 1'b0;
            end
            if (o_resp) seen = 1'b1;
        end
        check({tag, "_lat"}, 256'(seen ? k : 99), 256'(exp_lat));
        rdata   = o_rdata;
        b_read  = 1'b0;
        b_write = 1'b0;
    endtask

    localparam pmem_line_t L_A5  = {32{8'hA5}};
    localparam pmem_line_t L_200 = {8{32'h0200_CAFE}};
    localparam pmem_line_t L_100 = {8{32'h0100_BEEF}};
    localparam pmem_line_t L_C3  = {32{8'hC3}};
    localparam pmem_line_t L_11  = {32{8'h11}};
    localparam pmem_line_t L_77  = {16{16'h7711}};
    localparam pmem_line_t L_5A  = {32{8'h5A}};

    initial begin
        rst_n   = 1'b0;
        sel1    = 1'b0;
        b_read  = 1'b1;
        b_write = 1'b0;
        b_addr  = 32'h0000_0040;
        b_wdata = '0;
        step(3);
        check("rst_resp",  256'(o_resp), 256'(0));
        check("rst_rdata", o_rdata, '0);
        check("rst_err",   256'(o_err), 256'(0));

        // Held read accepted in the first IDLE cycle after release
        rst_n = 1'b1;
        xfer("post_rst", 1'b1, 1'b0, 32'h0000_0040, '0, 4, 0, rd);
        gap();

        xfer("wr40", 1'b0, 1'b1, 32'h0000_0040, L_A5, 4, 0, rd);
        gap();
        xfer("rd40", 1'b1, 1'b0, 32'h0000_0040, '0, 4, 0, rd);
        check("rd40_data", rd, L_A5);
        gap();
        check("rdata_hold", o_rdata, L_A5);

        // Write-back then fill with no gap
        xfer("wr200", 1'b0, 1'b1, 32'h0000_0200, L_200, 4, 0, rd);
        gap();
        xfer("wr100", 1'b0, 1'b1, 32'h0000_0100, L_100, 4, 0, rd);
        xfer("rd200", 1'b1, 1'b0, 32'h0000_0200, '0, 5, 0, rd);
        check("rd200_data", rd, L_200);
        gap();
        check("err_clean", 256'(o_err), 256'(0));

        // Aliasing and offset bits
        xfer("wr2020", 1'b0, 1'b1, 32'h0000_2020, L_C3, 4, 0, rd);
        gap();
        xfer("rd20", 1'b1, 1'b0, 32'h0000_0020, '0, 4, 0, rd);
        check("rd20_data", rd, L_C3);
        gap();
        xfer("rd3f", 1'b1, 1'b0, 32'h0000_003F, '0, 4, 0, rd);
        check("rd3f_data", rd, L_C3);
        gap();

        // Read strobe dropped during WAIT
        xfer("drop", 1'b1, 1'b0, 32'h0000_0040, '0, 4, 2, rd);
        check("drop_data", rd, L_A5);
        check("drop_err", 256'(o_err), 256'(1));
        gap();
        step(3);
        check("err_sticky", 256'(o_err), 256'(1));

        // Reset during WAIT of a write: no pulse, no commit
        b_write = 1'b1;
        b_addr  = 32'h0000_0040;
        b_wdata = L_11;
        step(2);
        rst_n   = 1'b0;
        b_write = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (i == 1) rst_n = 1'b1;
            check("rstmid_resp", 256'(o_resp), 256'(0));
        end
        check("rstmid_err", 256'(o_err), 256'(0));
        xfer("rd_old", 1'b1, 1'b0, 32'h0000_0040, '0, 4, 0, rd);
        check("rd_old_data", rd, L_A5);
        gap();

        // Both strobes: treated as a write
        xfer("both", 1'b1, 1'b1, 32'h0000_0300, L_77, 4, 0, rd);
        check("both_err", 256'(o_err), 256'(1));
        gap();
        xfer("rd300", 1'b1, 1'b0, 32'h0000_0300, '0, 4, 0, rd);
        check("rd300_data", rd, L_77);
        gap();

        // LATENCY=1 instance
        sel1 = 1'b1;
        xfer("l1_wr", 1'b0, 1'b1, 32'h0000_0060, L_5A, 1, 0, rd);
        xfer("l1_rd", 1'b1, 1'b0, 32'h0000_0060, '0, 2, 0, rd);
        check("l1_rd_data", rd, L_5A);
        gap();
        check("l1_err", 256'(o_err), 256'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
